// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Holds state names, opcode/funct values and the datapath select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_ALU = 4'd6,
    S_WB_MEM = 4'd7,
    S_WB_LUI = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_LUI    = 2'b10;
  localparam logic [1:0] WD_PC     = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_EXT     = 2'b10;
  localparam logic [1:0] SRCB_EXT_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  // At most one bit is set; all-zero means the encoding is unsupported.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic jal;
  } iclass_t;

endpackage

// File: rtl/mc_if.sv
// Control bundle between mc_ctrl (master) and the multi-cycle datapath (slave).
interface mc_if #(parameter int CNT_W = 32);

  logic [5:0]       op;
  logic [5:0]       func;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_rd;
  logic             mem_wr;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       wd_sel;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             ext_op;
  logic             illegal;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  op, func, zero, mem_ready,
    output pc_write, pc_src, ir_write, i_or_d, mem_rd, mem_wr, reg_write,
           reg_dst, wd_sel, alu_src_a, alu_src_b, alu_op, ext_op, illegal,
           state_o, instr_cnt
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  pc_write, pc_src, ir_write, i_or_d, mem_rd, mem_wr, reg_write,
           reg_dst, wd_sel, alu_src_a, alu_src_b, alu_op, ext_op, illegal,
           state_o, instr_cnt
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: (op, func) -> one-hot class + illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output iclass_t    cls_o,
  output logic       illegal_o
);

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    cls_o = '0;
    unique case (op_i)
      OP_RTYPE: begin
        unique case (func_i)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_JR:   cls_o.jr   = 1'b1;
          FN_NOP:  cls_o.nop  = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: ;
    endcase
    illegal_o = (cls_o == '0);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared memory port and ALU,
// drives all datapath selects/enables and counts retired instructions.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iclass_t          cls;
  logic             dec_illegal;
  logic             retire;

  logic       pc_write, ir_write, i_or_d, mem_rd, mem_wr, reg_write;
  logic       alu_src_a, ext_op, illegal;
  logic [1:0] pc_src, reg_dst, wd_sel, alu_src_b, alu_op;

  // op/func stay stable until the next FETCH, so later states re-decode them.
  mc_decode u_decode (
    .op_i      (bus.op),
    .func_i    (bus.func),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_ALU;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_write = 1'b0;
    reg_dst   = RD_RT;
    wd_sel    = WD_ALUOUT;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REG;
    alu_op    = ALU_ADD;
    ext_op    = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_EXT_SH2;
        ext_op    = 1'b1;
        if (cls.addu || cls.subu)              state_d = S_EXEC_R;
        else if (cls.ori || cls.lw || cls.sw)  state_d = S_EXEC_I;
        else if (cls.beq)                      state_d = S_BRANCH;
        else if (cls.lui)                      state_d = S_WB_LUI;
        else if (cls.jal || cls.jr)            state_d = S_JUMP;
        else begin
          state_d = S_FETCH;
          retire  = cls.nop;
          illegal = dec_illegal;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = cls.subu ? ALU_SUB : ALU_ADD;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
        if (cls.ori) begin
          alu_op  = ALU_OR;
          state_d = S_WB_ALU;
        end else begin
          ext_op  = 1'b1;
          state_d = cls.lw ? S_MEM_RD : S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        i_or_d = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        i_or_d = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = cls.ori ? RD_RT : RD_RD;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wd_sel    = WD_MDR;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_WB_LUI: begin
        reg_write = 1'b1;
        wd_sel    = WD_LUI;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = bus.zero;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        if (cls.jal) begin
          pc_src    = PC_JUMP;
          reg_write = 1'b1;
          reg_dst   = RD_RA;
          wd_sel    = WD_PC;
        end else begin
          pc_src    = PC_REG;
        end
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign cnt_d = cnt_q + CNT_W'(retire);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write strobes are gated by reset so an aborted access never commits.
  assign bus.pc_write  = pc_write  & reset;
  assign bus.ir_write  = ir_write  & reset;
  assign bus.reg_write = reg_write & reset;
  assign bus.mem_wr    = mem_wr    & reset;
  assign bus.pc_src    = pc_src;
  assign bus.i_or_d    = i_or_d;
  assign bus.mem_rd    = mem_rd;
  assign bus.reg_dst   = reg_dst;
  assign bus.wd_sel    = wd_sel;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.alu_op    = alu_op;
  assign bus.ext_op    = ext_op;
  assign bus.illegal   = illegal;
  assign bus.state_o   = state_q;
  assign bus.instr_cnt = cnt_q;

endmodule
